// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber matrix-vector scheduler: FSM encoding,
// legal rank bounds and a rank-check helper.
package kyber_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FULL,
        CAL,
        WAIT_LOW,
        WAIT_HIGH,
        DRAIN,
        FIN
    } sched_state_t;

    localparam logic [2:0] KYBER_K_MIN = 3'd2;
    localparam logic [2:0] KYBER_K_MAX = 3'd4;

    function automatic logic k_is_valid(input logic [2:0] k);
        return (k >= KYBER_K_MIN) && (k <= KYBER_K_MAX);
    endfunction

endpackage

// File: rtl/stream_drain.sv
// Streams one result polynomial out of the accumulator RAM (1-cycle read
// latency) over ready/valid, with the read address held under backpressure.
module stream_drain #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             out_ready,
    output logic [DEPTH-1:0] rd_addr,
    output logic             out_valid,
    output logic [DEPTH-1:0] out_idx,
    output logic             last
);

    logic [DEPTH-1:0] idx_reg;
    logic             pend_reg;
    logic             valid_reg;
    logic             fire;

    assign fire      = valid_reg && out_ready;
    assign last      = fire && (idx_reg == {DEPTH{1'b1}});
    assign out_valid = valid_reg;
    assign out_idx   = idx_reg;
    // Look one address ahead only when the current beat leaves, so a stalled
    // beat keeps re-reading its own coefficient.
    assign rd_addr   = fire ? idx_reg + DEPTH'(1) : idx_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_reg   <= '0;
            pend_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            pend_reg <= start;
            if (pend_reg) begin
                valid_reg <= 1'b1;
            end else if (last) begin
                valid_reg <= 1'b0;
                idx_reg   <= '0;
            end else if (fire) begin
                idx_reg <= idx_reg + DEPTH'(1);
            end
        end
    end

endmodule

// File: rtl/polyvec_matvec_sched.sv
// Row-by-row scheduler for a Kyber matrix-vector product on a single
// basemul-accumulate instance: load, full_in, cal_en, wait done, drain.
module polyvec_matvec_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       k_sel,
    input  logic             transpose,
    output logic             load_req,
    output logic [1:0]       load_row,
    output logic             load_transpose,
    input  logic             load_done,
    output logic             acc_full_in,
    output logic             acc_cal_en,
    input  logic             acc_done,
    output logic [DEPTH-1:0] acc_rd_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_row,
    output logic [DEPTH-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import kyber_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    sched_state_t   state_reg, state_next;
    logic [1:0]     row_reg, row_next;
    logic [2:0]     k_reg, k_next;
    logic           tr_reg, tr_next;
    logic           err_reg, err_next;
    logic           done_reg, done_next;
    logic [TW-1:0]  tcnt_reg, tcnt_next;
    logic           drain_start;
    logic           drain_last;

    stream_drain #(.DEPTH(DEPTH)) u_drain (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (drain_start),
        .out_ready (out_ready),
        .rd_addr   (acc_rd_addr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .last      (drain_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            k_reg     <= '0;
            tr_reg    <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            k_reg     <= k_next;
            tr_reg    <= tr_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        k_next      = k_reg;
        tr_next     = tr_reg;
        err_next    = err_reg;
        done_next   = 1'b0;
        tcnt_next   = tcnt_reg;
        drain_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (!k_is_valid(k_sel)) begin
                        err_next  = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        k_next     = k_sel;
                        tr_next    = transpose;
                        row_next   = '0;
                        err_next   = 1'b0;
                        state_next = LOAD;
                    end
                end
            end
            LOAD:  if (load_done) state_next = FULL;
            FULL:  state_next = CAL;
            CAL: begin
                tcnt_next  = '0;
                state_next = WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
                // The timeout wins over a coincident acc_done edge.
                if (tcnt_reg == T_LAST) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                    if (state_reg == WAIT_LOW && !acc_done) begin
                        state_next = WAIT_HIGH;
                    end else if (state_reg == WAIT_HIGH && acc_done) begin
                        state_next  = DRAIN;
                        drain_start = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    if ({1'b0, row_reg} == k_reg - 3'd1) begin
                        state_next = FIN;
                    end else begin
                        row_next   = row_reg + 2'd1;
                        state_next = LOAD;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign load_req       = (state_reg == LOAD);
    assign load_row       = row_reg;
    assign load_transpose = tr_reg;
    assign acc_full_in    = (state_reg == FULL);
    assign acc_cal_en     = (state_reg == CAL);
    assign out_row        = row_reg;
    assign busy           = (state_reg != IDLE);
    assign done           = done_reg || (state_reg == FIN);
    assign err            = err_reg;

endmodule

// File: tb/tb_polyvec_matvec_sched.sv
// Randomized bench: behavioural data mover, accumulator and result RAM around
// the scheduler; expected beats are queued at start and checked by a monitor.
module tb_polyvec_matvec_sched;
    localparam int DEPTH   = 8;
    localparam int NCOEF   = 1 << DEPTH;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       k_sel = '0;
    logic             transpose = 1'b0;
    logic             load_req;
    logic [1:0]       load_row;
    logic             load_transpose;
    logic             load_done = 1'b0;
    logic             acc_full_in;
    logic             acc_cal_en;
    logic             acc_done = 1'b0;
    logic [DEPTH-1:0] acc_rd_addr;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out_row;
    logic [DEPTH-1:0] out_idx;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int failures = 0;

    // environment configuration
    int mover_delay = 5;
    int stale_cycles = 0;
    int hi_delay = 20;
    int ready_mode = 0;
    bit acc_enable = 1'b1;
    bit exp_tr = 1'b0;

    int calcnt = 0;
    bit fresh = 1'b0;
    int ram_q = 0;
    int cyc = 0;
    int beats = 0;
    int done_count = 0;
    int done_cycle = -1;
    int last_beat_cycle = -1;
    int cal_cycle = -1;
    int exp_q[$];
    int e;

    bit p_valid, p_ready, p_ld, p_req, p_full;
    logic [DEPTH-1:0] p_idx, p_addr;
    logic [1:0] p_row;

    polyvec_matvec_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .k_sel(k_sel),
        .transpose(transpose), .load_req(load_req), .load_row(load_row),
        .load_transpose(load_transpose), .load_done(load_done),
        .acc_full_in(acc_full_in), .acc_cal_en(acc_cal_en), .acc_done(acc_done),
        .acc_rd_addr(acc_rd_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_idx(out_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result RAM: coefficient i of row r holds r*NCOEF+i, one-cycle read.
    always @(posedge clk) ram_q <= (calcnt - 1) * NCOEF + int'(acc_rd_addr);

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // data mover
    initial begin
        int mv_cnt;
        mv_cnt = 0;
        forever begin
            tick();
            if (!reset_n) begin
                load_done = 1'b0;
                mv_cnt = 0;
            end else if (load_done) begin
                load_done = 1'b0;
            end else if (load_req) begin
                mv_cnt++;
                if (mv_cnt >= mover_delay) begin
                    load_done = 1'b1;
                    mv_cnt = 0;
                end
            end else begin
                mv_cnt = 0;
            end
        end
    end

    // accumulator: stale done held for stale_cycles, then low, then rises
    initial begin
        int acc_phase, acc_cnt;
        acc_phase = 0;
        acc_cnt = 0;
        forever begin
            tick();
            if (!reset_n) begin
                acc_done = 1'b0;
                acc_phase = 0;
                fresh = 1'b0;
            end else if (acc_cal_en) begin
                calcnt++;
                fresh = 1'b0;
                acc_cnt = 0;
                acc_phase = 1;
                if (stale_cycles == 0) begin
                    acc_done = 1'b0;
                    fresh = 1'b1;
                    acc_phase = 2;
                end
            end else if (acc_phase == 1) begin
                acc_cnt++;
                if (acc_cnt >= stale_cycles) begin
                    acc_done = 1'b0;
                    fresh = 1'b1;
                    acc_phase = 2;
                    acc_cnt = 0;
                end
            end else if (acc_phase == 2) begin
                acc_cnt++;
                if (acc_cnt >= hi_delay && acc_enable) begin
                    acc_done = 1'b1;
                    acc_phase = 0;
                end
            end
        end
    end

    // consumer ready pattern
    initial begin
        forever begin
            tick();
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            p_valid = 0; p_ready = 0; p_ld = 0; p_req = 0; p_full = 0;
        end else begin
            if (out_valid && out_ready) begin
                beats++;
                last_beat_cycle = cyc;
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 1'b0, int'(out_row) * NCOEF + int'(out_idx), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_row_idx", (int'(out_row) * NCOEF + int'(out_idx)) == e,
                        int'(out_row) * NCOEF + int'(out_idx), e);
                    chk("beat_data", ram_q == e, ram_q, e);
                end
            end
            if (p_valid && !p_ready)
                chk("stall_hold", out_valid && out_idx == p_idx && out_row == p_row &&
                    (out_ready || acc_rd_addr == p_addr), out_idx, p_idx);
            if (out_valid && !p_valid)
                chk("drain_after_fresh_done", fresh, fresh, 1);
            if (acc_full_in || (p_ld && p_req))
                chk("full_in_after_load_done", acc_full_in == (p_ld && p_req) && !acc_cal_en,
                    acc_full_in, p_ld && p_req);
            if (acc_cal_en || p_full)
                chk("cal_en_after_full_in", acc_cal_en == p_full, acc_cal_en, p_full);
            if (load_req)
                chk("load_transpose", load_transpose == exp_tr, load_transpose, exp_tr);
            if (acc_cal_en) cal_cycle = cyc;
            if (done) begin
                done_count++;
                done_cycle = cyc;
            end
            p_valid = out_valid; p_ready = out_ready; p_ld = load_done;
            p_req = load_req; p_full = acc_full_in;
            p_idx = out_idx; p_addr = acc_rd_addr; p_row = out_row;
        end
    end

    task automatic issue_start(input logic [2:0] k, input bit tr);
        k_sel = k;
        transpose = tr;
        calcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_expected(input int k);
        for (int r = 0; r < k; r++)
            for (int i = 0; i < NCOEF; i++)
                exp_q.push_back(r * NCOEF + i);
    endtask

    task automatic run_product(input int k, input bit tr);
        int d0, budget;
        beats = 0;
        d0 = done_count;
        exp_tr = tr;
        push_expected(k);
        issue_start(3'(k), tr);
        chk("start_busy_load_req", busy && load_req && load_row == 0 && !done && !err,
            {busy, load_req, done, err}, 4'b1100);
        budget = 0;
        while (done_count == d0 && budget < 6000) begin
            tick();
            budget++;
        end
        chk("product_done_seen", done_count == d0 + 1, done_count - d0, 1);
        chk("beat_count", beats == k * NCOEF, beats, k * NCOEF);
        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        chk("done_after_last_beat", done_cycle == last_beat_cycle + 1,
            done_cycle - last_beat_cycle, 1);
        chk("busy_low_err_clear", !busy && !err, {busy, err}, 0);
        tick();
        tick();
        chk("single_done_pulse", done_count == d0 + 1, done_count - d0, 1);
        exp_q.delete();
    endtask

    initial begin
        int d0, budget;
        logic [2:0] bad_k [4];
        bad_k[0] = 3'd5; bad_k[1] = 3'd0; bad_k[2] = 3'd1; bad_k[3] = 3'd7;

        reset_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs_zero",
            {load_req, load_row, load_transpose, acc_full_in, acc_cal_en, acc_rd_addr,
             out_valid, out_row, out_idx, busy, done, err} == '0,
            {load_req, load_row, load_transpose, acc_full_in, acc_cal_en, acc_rd_addr,
             out_valid, out_row, out_idx, busy, done, err}, 0);
        reset_n = 1'b1;
        tick();

        // k=3, ready always high
        ready_mode = 0; mover_delay = 5; hi_delay = 20; stale_cycles = 0;
        run_product(3, 1'b0);

        // k=2, ready toggling
        ready_mode = 1;
        run_product(2, 1'b1);

        // stale done held over from the previous row
        ready_mode = 2; stale_cycles = 3;
        run_product(3, 1'b0);
        stale_cycles = 0;

        // timeout: acc_done never rises
        acc_enable = 1'b0; ready_mode = 0; beats = 0; exp_tr = 1'b0;
        d0 = done_count;
        issue_start(3'd2, 1'b0);
        budget = 0;
        while (done_count == d0 && budget < 400) begin
            tick();
            budget++;
        end
        chk("timeout_done", done_count == d0 + 1, done_count - d0, 1);
        chk("timeout_latency", done_cycle - cal_cycle == TIMEOUT + 1,
            done_cycle - cal_cycle, TIMEOUT + 1);
        chk("timeout_err_busy", err && !busy && beats == 0, {err, busy}, 2'b10);
        acc_enable = 1'b1;
        tick();
        run_product(2, 1'b1);

        // invalid ranks
        for (int j = 0; j < 4; j++) begin
            d0 = done_count;
            issue_start(bad_k[j], 1'b0);
            chk("bad_k_done_err", done && err && !busy && !load_req,
                {done, err, busy, load_req}, 4'b1100);
            repeat (3) tick();
            chk("bad_k_idle", done_count == d0 + 1 && !load_req && !acc_full_in &&
                !acc_cal_en && !busy, done_count - d0, 1);
        end

        // reset in the middle of draining row 1
        ready_mode = 0; exp_tr = 1'b1;
        push_expected(4);
        issue_start(3'd4, 1'b1);
        budget = 0;
        while (!(out_valid && out_row == 2'd1 && out_idx == 8'd10) && budget < 3000) begin
            tick();
            budget++;
        end
        chk("reached_row1_drain", out_valid && out_row == 2'd1, out_row, 1);
        reset_n = 1'b0;
        tick();
        chk("mid_reset_outputs_zero",
            {load_req, load_row, load_transpose, acc_full_in, acc_cal_en, acc_rd_addr,
             out_valid, out_row, out_idx, busy, done, err} == '0,
            {load_req, load_row, load_transpose, acc_full_in, acc_cal_en, acc_rd_addr,
             out_valid, out_row, out_idx, busy, done, err}, 0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        run_product(4, 1'b0);

        // randomized products
        for (int n = 0; n < 3; n++) begin
            ready_mode   = $urandom_range(0, 2);
            mover_delay  = $urandom_range(1, 6);
            stale_cycles = $urandom_range(0, 4);
            hi_delay     = $urandom_range(1, 25);
            run_product($urandom_range(2, 4), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
